// File: rtl/convolution_3by3_sequencer.sv
// Control sequencer for the 3x3 convolution datapath: drives operand-mux selects through the
// 9-tap feed and zero drain, then reads the four results out of the buffer under valid/ready.
module convolution_3by3_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [4:0]  ZERO_ADDR    = 5'd25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out_ready,
  output logic [4:0] input_side_array_addr_in_3by3,
  output logic [4:0] input_ceiling_array_addr_in_3by3,
  output logic [4:0] filter_side_array_addr_in_3by3,
  output logic [4:0] filter_ceiling_array_addr_in_3by3,
  output logic       sys_3by3_en,
  output logic [1:0] buffer_read_addr_in_3by3,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] raddr_q, raddr_d;
  logic [4:0] isd_q, isd_d, icl_q, icl_d, fsd_q, fsd_d, fcl_q, fcl_d;
  logic       en_q, en_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] p_s, q_s;
  logic       xfer_s;

  assign xfer_s = valid_q & out_ready;

  // Next-state, tap counter and read index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = 4'd0;
        raddr_d = 2'd0;
        if (start) begin
          state_d = S_FEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (cnt_q == 4'd8) begin
          state_d = S_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_READ;
          cnt_d   = 4'd0;
          raddr_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        if (xfer_s) begin
          if (raddr_q == 2'd3) begin
            state_d = S_DONE;
            raddr_d = 2'd0;
          end else begin
            raddr_d = raddr_q + 2'd1;
          end
        end else begin
          raddr_d = raddr_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        raddr_d = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        raddr_d = 2'd0;
      end
    endcase
  end

  // Split the next tap index into row p and column q of the 3x3 window.
  always_comb begin
    p_s = 2'd0;
    q_s = 2'd0;
    case (cnt_d)
      4'd0:    begin p_s = 2'd0; q_s = 2'd0; end
      4'd1:    begin p_s = 2'd0; q_s = 2'd1; end
      4'd2:    begin p_s = 2'd0; q_s = 2'd2; end
      4'd3:    begin p_s = 2'd1; q_s = 2'd0; end
      4'd4:    begin p_s = 2'd1; q_s = 2'd1; end
      4'd5:    begin p_s = 2'd1; q_s = 2'd2; end
      4'd6:    begin p_s = 2'd2; q_s = 2'd0; end
      4'd7:    begin p_s = 2'd2; q_s = 2'd1; end
      4'd8:    begin p_s = 2'd2; q_s = 2'd2; end
      default: begin p_s = 2'd0; q_s = 2'd0; end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    isd_d   = ZERO_ADDR;
    icl_d   = ZERO_ADDR;
    fsd_d   = ZERO_ADDR;
    fcl_d   = ZERO_ADDR;
    en_d    = 1'b0;
    valid_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = 1'b0;
    case (state_d)
      S_FEED: begin
        isd_d = {1'b0, p_s, 2'b00} + {3'b000, q_s};
        icl_d = {1'b0, p_s, 2'b00} + {3'b000, q_s} + 5'd5;
        fsd_d = 5'd16 + {2'b00, p_s, 1'b0} + {3'b000, p_s} + {3'b000, q_s};
        fcl_d = 5'd16 + {2'b00, p_s, 1'b0} + {3'b000, p_s} + {3'b000, q_s};
        en_d  = 1'b1;
      end
      S_DRAIN: en_d    = 1'b1;
      S_READ:  valid_d = 1'b1;
      S_DONE:  done_d  = 1'b1;
      S_IDLE:  busy_d  = 1'b0;
      default: busy_d  = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      raddr_q <= 2'd0;
      isd_q   <= ZERO_ADDR;
      icl_q   <= ZERO_ADDR;
      fsd_q   <= ZERO_ADDR;
      fcl_q   <= ZERO_ADDR;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      isd_q   <= isd_d;
      icl_q   <= icl_d;
      fsd_q   <= fsd_d;
      fcl_q   <= fcl_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign input_side_array_addr_in_3by3     = isd_q;
  assign input_ceiling_array_addr_in_3by3  = icl_q;
  assign filter_side_array_addr_in_3by3    = fsd_q;
  assign filter_ceiling_array_addr_in_3by3 = fcl_q;
  assign sys_3by3_en                       = en_q;
  assign buffer_read_addr_in_3by3          = raddr_q;
  assign out_valid                         = valid_q;
  assign busy                              = busy_q;
  assign done                              = done_q;

endmodule

// File: tb/tb_convolution_3by3_sequencer.sv
// Self-checking bench for convolution_3by3_sequencer: per-cycle expected records in a scoreboard queue,
// result-beat order checked against a small buffer model, selects replayed through a toy datapath.
module tb_convolution_3by3_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [4:0] isd, icl, fsd, fcl;
  logic       en, valid, busy, done;
  logic [1:0] raddr;

  convolution_3by3_sequencer dut (
    .clk                               (clk),
    .rst                               (rst),
    .start                             (start),
    .out_ready                         (out_ready),
    .input_side_array_addr_in_3by3     (isd),
    .input_ceiling_array_addr_in_3by3  (icl),
    .filter_side_array_addr_in_3by3    (fsd),
    .filter_ceiling_array_addr_in_3by3 (fcl),
    .sys_3by3_en                       (en),
    .buffer_read_addr_in_3by3          (raddr),
    .out_valid                         (valid),
    .busy                              (busy),
    .done                              (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] isd, icl, fsd, fcl;
    logic       en;
    logic [1:0] addr;
    logic       valid, busy, done;
  } exp_t;
  typedef struct packed { logic st; logic rdy; } stim_t;
  typedef struct packed { logic [4:0] isd, icl, fsd; } tap_t;

  tap_t  taps [9];
  exp_t  exp_q [$];
  stim_t stim_q [$];
  string tag_q [$];
  int    beat_q [$];
  int    a_m [16];
  int    b_m [9];
  int    buf_m [4];
  int    acc11, acc22;
  logic  pend_ready;
  int    total = 0;
  int    bad = 0;

  function automatic exp_t mk(input logic [4:0] i_s, input logic [4:0] i_c, input logic [4:0] f_s,
                              input logic [4:0] f_c, input logic e, input logic [1:0] a,
                              input logic v, input logic b, input logic d);
    exp_t r;
    r.isd = i_s; r.icl = i_c; r.fsd = f_s; r.fcl = f_c;
    r.en = e; r.addr = a; r.valid = v; r.busy = b; r.done = d;
    return r;
  endfunction

  function automatic exp_t idle_rec();
    return mk(5'd25, 5'd25, 5'd25, 5'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic int mux(input logic [4:0] sel);
    if (sel < 5'd16) return a_m[sel];
    else if (sel < 5'd25) return b_m[sel - 5'd16];
    else return 0;
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t g;
    g = mk(isd, icl, fsd, fcl, en, raddr, valid, busy, done);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got isd=%0d icl=%0d fsd=%0d fcl=%0d en=%0b addr=%0d v=%0b busy=%0b done=%0b, want isd=%0d icl=%0d fsd=%0d fcl=%0d en=%0b addr=%0d v=%0b busy=%0b done=%0b",
               tag, g.isd, g.icl, g.fsd, g.fcl, g.en, g.addr, g.valid, g.busy, g.done,
               e.isd, e.icl, e.fsd, e.fcl, e.en, e.addr, e.valid, e.busy, e.done);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic push(input logic st, input exp_t e, input string tag, input logic rdy_next);
    stim_q.push_back({st, pend_ready});
    exp_q.push_back(e);
    tag_q.push_back(tag);
    pend_ready = rdy_next;
  endtask

  // One full run from the start-sampling edge through the done pulse.
  task automatic push_run(input logic st_first, input logic st_rest, input int busy_tick,
                          input int stall_addr, input int stall_len);
    int n;
    for (int t = 0; t < 9; t++)
      push((t == 0) ? st_first : (st_rest | (t == busy_tick)),
           mk(taps[t].isd, taps[t].icl, taps[t].fsd, taps[t].fsd, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0),
           $sformatf("tap%0d", t), 1'b0);
    for (int d = 0; d < 4; d++)
      push(st_rest, mk(5'd25, 5'd25, 5'd25, 5'd25, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0),
           $sformatf("drain%0d", d), 1'b0);
    for (int a = 0; a < 4; a++) begin
      n = (a == stall_addr) ? stall_len + 1 : 1;
      for (int j = 0; j < n; j++)
        push(st_rest, mk(5'd25, 5'd25, 5'd25, 5'd25, 1'b0, 2'(a), 1'b1, 1'b1, 1'b0),
             $sformatf("read%0d_%0d", a, j), (j == n - 1));
    end
    push(st_rest, mk(5'd25, 5'd25, 5'd25, 5'd25, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1), "done", 1'b1);
    beat_q.push_back(54); beat_q.push_back(63); beat_q.push_back(90); beat_q.push_back(99);
  endtask

  // Apply up to n queued cycles; called and returning at a negative edge.
  task automatic run_queue(input int n);
    stim_t s;
    exp_t  e;
    string tag;
    int    k;
    k = 0;
    while (stim_q.size() > 0 && k < n) begin
      s = stim_q.pop_front();
      start = s.st;
      out_ready = s.rdy;
      if (en) begin
        acc11 += mux(isd) * mux(fsd);
        acc22 += mux(icl) * mux(fcl);
      end
      if (valid && out_ready) begin
        if (beat_q.size() == 0) check_int("beat_extra", buf_m[raddr], -1);
        else check_int("beat", buf_m[raddr], beat_q.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      tag = tag_q.pop_front();
      check(tag, e);
      k++;
    end
  endtask

  initial begin
    taps = '{'{5'd0, 5'd5, 5'd16}, '{5'd1, 5'd6, 5'd17}, '{5'd2, 5'd7, 5'd18},
             '{5'd4, 5'd9, 5'd19}, '{5'd5, 5'd10, 5'd20}, '{5'd6, 5'd11, 5'd21},
             '{5'd8, 5'd13, 5'd22}, '{5'd9, 5'd14, 5'd23}, '{5'd10, 5'd15, 5'd24}};
    for (int i = 0; i < 16; i++) a_m[i] = i + 1;
    for (int i = 0; i < 9; i++) b_m[i] = 1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        buf_m[2*r+c] = 0;
        for (int p = 0; p < 3; p++)
          for (int q = 0; q < 3; q++)
            buf_m[2*r+c] += a_m[4*(r+p) + (c+q)] * b_m[3*p+q];
      end
    acc11 = 0;
    acc22 = 0;
    pend_ready = 1'b1;

    // Reset held with start asserted.
    rst = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", idle_rec());
    end
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, idle_rec(), "idle_after_reset", 1'b1);
    run_queue(1000);

    // Nominal run, then backpressure at addr 1.
    push_run(1'b1, 1'b0, -1, -1, 0);
    push(1'b0, idle_rec(), "idle_nom", 1'b1);
    push_run(1'b1, 1'b0, -1, 1, 3);
    push(1'b0, idle_rec(), "idle_bp", 1'b1);
    run_queue(1000);

    // start while busy, then start held high for back-to-back runs.
    push_run(1'b1, 1'b0, 5, -1, 0);
    push(1'b0, idle_rec(), "idle_busystart", 1'b1);
    push_run(1'b1, 1'b1, -1, -1, 0);
    push(1'b1, idle_rec(), "b2b_gap", 1'b1);
    push_run(1'b1, 1'b1, -1, -1, 0);
    push(1'b0, idle_rec(), "idle_b2b", 1'b1);
    run_queue(1000);

    // Async reset in the middle of a DRAIN cycle.
    push_run(1'b1, 1'b0, -1, -1, 0);
    run_queue(11);
    #2 rst = 1'b0;
    #1 check("async_rst", idle_rec());
    @(negedge clk);
    check("async_rst_hold", idle_rec());
    rst = 1'b1;
    stim_q.delete(); exp_q.delete(); tag_q.delete(); beat_q.delete();
    pend_ready = 1'b1;

    // Clean run after the abort, replayed through a toy datapath.
    acc11 = 0;
    acc22 = 0;
    push(1'b0, idle_rec(), "idle_post_abort", 1'b1);
    push_run(1'b1, 1'b0, -1, -1, 0);
    push(1'b0, idle_rec(), "idle_end", 1'b1);
    run_queue(1000);
    check_int("c11_from_selects", acc11, 54);
    check_int("c22_from_selects", acc22, 99);
    check_int("beats_left", beat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
